dma_line_ctrl: RTL and testbench

Disk-to-main-memory DMA engine. It sits directly upstream of the main memory and is programmed through the memory-mapped DMA register window at 0x8000_0000–0x8000_000C. When started, it copies a block from the disk model into main memory, one 32-byte line at a time. It fetches each line from disk, buffers it, writes it to memory as a full-line write, and signals completion with a status bit and a one-cycle interrupt pulse.

---
 rtl/dma_line_ctrl.sv | 155 +++++++++++++++
 tb/tb_dma_line_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_line_ctrl.sv
// dma_line_ctrl: disk-to-main-memory DMA engine, one line per disk read / memory write pair.
module dma_line_ctrl #(
    parameter int unsigned LINE_BYTES = 32,
    parameter int unsigned MEM_AW     = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    reg_wr_en,
    input  logic                    reg_rd_en,
    input  logic [3:0]              reg_addr,
    input  logic [31:0]             reg_wdata,
    output logic [31:0]             reg_rdata,
    output logic                    disk_rd_req,
    output logic [31:0]             disk_addr,
    input  logic                    disk_rd_ack,
    input  logic [LINE_BYTES*8-1:0] disk_rdata,
    output logic                    mem_wr_req,
    output logic [MEM_AW-1:0]       mem_addr,
    output logic [LINE_BYTES*8-1:0] mem_wdata,
    input  logic                    mem_wr_ack,
    output logic                    dma_busy,
    output logic                    dma_done_irq
);
    localparam int unsigned       LW             = LINE_BYTES * 8;
    localparam logic [31:0]       DISK_LINE_MASK = ~32'(LINE_BYTES - 1);
    localparam logic [MEM_AW-1:0] MEM_LINE_MASK  = ~MEM_AW'(LINE_BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_DISK_RD, S_MEM_WR, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_disk_addr;
    logic [MEM_AW-1:0] r_mem_addr;
    logic [15:0]       r_tsize;
    logic              r_done;
    logic [31:0]       r_cur_disk;
    logic [MEM_AW-1:0] r_cur_mem;
    logic [11:0]       r_lines;
    logic [LW-1:0]     r_buf;
    logic [31:0]       r_rdata;

    logic              w_idle;
    logic              w_start;
    logic              w_disk_fire;
    logic              w_mem_fire;
    logic [16:0]       w_tsize_round;
    logic [11:0]       w_lines_init;

    assign w_idle        = (r_state == S_IDLE);
    assign w_start       = reg_wr_en && (reg_addr == 4'hC) && reg_wdata[0] && w_idle && (r_tsize != '0);
    assign w_tsize_round = {1'b0, r_tsize} + 17'(LINE_BYTES - 1);
    assign w_lines_init  = 12'(w_tsize_round >> $clog2(LINE_BYTES));

    assign disk_addr = r_cur_disk;
    assign mem_addr  = r_cur_mem;
    assign mem_wdata = r_buf;
    assign reg_rdata = r_rdata;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        w_state_nxt  = r_state;
        disk_rd_req  = 1'b0;
        mem_wr_req   = 1'b0;
        dma_busy     = 1'b1;
        dma_done_irq = 1'b0;
        w_disk_fire  = 1'b0;
        w_mem_fire   = 1'b0;
        case (r_state)
            S_IDLE: begin
                dma_busy = 1'b0;
                if (w_start) w_state_nxt = S_DISK_RD;
            end
            S_DISK_RD: begin
                disk_rd_req = 1'b1;
                w_disk_fire = disk_rd_ack;
                if (disk_rd_ack) w_state_nxt = S_MEM_WR;
            end
            S_MEM_WR: begin
                mem_wr_req = 1'b1;
                w_mem_fire = mem_wr_ack;
                if (mem_wr_ack) w_state_nxt = (r_lines == 12'd1) ? S_DONE : S_DISK_RD;
            end
            S_DONE: begin
                dma_done_irq = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Programming registers; writes are only accepted while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disk_addr <= '0;
            r_mem_addr  <= '0;
            r_tsize     <= '0;
            r_done      <= 1'b0;
        end else begin
            if (reg_wr_en && w_idle) begin
                case (reg_addr)
                    4'h0:    r_disk_addr <= reg_wdata;
                    4'h4:    r_mem_addr  <= reg_wdata[MEM_AW-1:0];
                    4'h8:    r_tsize     <= reg_wdata[15:0];
                    default: ;
                endcase
            end
            if (w_start)                 r_done <= 1'b0;
            else if (r_state == S_DONE)  r_done <= 1'b1;
        end
    end

    // Transfer datapath: running addresses, remaining line count and line buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_disk <= '0;
            r_cur_mem  <= '0;
            r_lines    <= '0;
            r_buf      <= '0;
        end else begin
            if (w_start) begin
                r_cur_disk <= r_disk_addr & DISK_LINE_MASK;
                r_cur_mem  <= r_mem_addr & MEM_LINE_MASK;
                r_lines    <= w_lines_init;
            end
            if (w_disk_fire) r_buf <= disk_rdata;
            if (w_mem_fire) begin
                r_lines    <= r_lines - 12'd1;
                r_cur_disk <= r_cur_disk + 32'(LINE_BYTES);
                r_cur_mem  <= r_cur_mem + MEM_AW'(LINE_BYTES);
            end
        end
    end

    // Registered read port; holds its value when no read is requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (reg_rd_en) begin
            case (reg_addr)
                4'h0:    r_rdata <= r_disk_addr;
                4'h4:    r_rdata <= 32'(r_mem_addr);
                4'h8:    r_rdata <= {16'h0, r_tsize};
                4'hC:    r_rdata <= {30'h0, r_done, dma_busy};
                default: r_rdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_line_ctrl.sv
// tb_dma_line_ctrl: register table, directed transfers and randomized transfers
// checked against a line-list reference model.
`timescale 1ns/1ps
module tb_dma_line_ctrl;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         reg_wr_en, reg_rd_en;
    logic [3:0]   reg_addr;
    logic [31:0]  reg_wdata, reg_rdata;
    logic         disk_rd_req;
    logic [31:0]  disk_addr;
    logic         disk_rd_ack = 1'b0;
    logic [255:0] disk_rdata  = '0;
    logic         mem_wr_req;
    logic [14:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic         mem_wr_ack  = 1'b0;
    logic         dma_busy, dma_done_irq;

    dma_line_ctrl #(.LINE_BYTES(32), .MEM_AW(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .disk_rd_req(disk_rd_req), .disk_addr(disk_addr),
        .disk_rd_ack(disk_rd_ack), .disk_rdata(disk_rdata),
        .mem_wr_req(mem_wr_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wr_ack(mem_wr_ack), .dma_busy(dma_busy), .dma_done_irq(dma_done_irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Disk content: byte i of the line at address a.
    function automatic logic [255:0] line_data(input logic [31:0] a);
        logic [255:0] d;
        for (int i = 0; i < 32; i++) d[i*8 +: 8] = (8'(i) + a[7:0]) ^ a[23:16] ^ a[31:24];
        return d;
    endfunction

    // Disk / memory responders with programmable ack latency and stray acks.
    int           ack_delay = 0;
    bit           ack_rand  = 0;
    bit           spur      = 0;
    bit           dpend = 0, mpend = 0, d_acked = 0, m_acked = 0;
    int           dwait, mwait;
    logic [31:0]  d_addr0;
    logic [14:0]  m_addr0;
    logic [255:0] m_data0;
    logic [31:0]  disk_log[$];
    logic [14:0]  mem_alog[$];
    logic [255:0] mem_dlog[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            disk_rd_ack = 1'b0; mem_wr_ack = 1'b0;
            dpend = 0; mpend = 0; d_acked = 0; m_acked = 0;
        end else begin
            if (d_acked) begin
                d_acked = 0; dpend = 0; disk_rd_ack = 1'b0;
                chk("disk_req_drop", 256'(disk_rd_req), 256'(0));
            end else if (disk_rd_req) begin
                disk_rd_ack = 1'b0;
                if (!dpend) begin
                    dpend = 1; d_addr0 = disk_addr;
                    dwait = ack_rand ? int'($urandom_range(0, 3)) : ack_delay;
                end else begin
                    chk("disk_addr_stable", 256'(disk_addr), 256'(d_addr0));
                end
                if (dwait == 0) begin
                    disk_rd_ack = 1'b1; d_acked = 1;
                    disk_rdata = line_data(disk_addr);
                    disk_log.push_back(disk_addr);
                end else dwait--;
            end else begin
                disk_rd_ack = spur ? 1'($urandom_range(0, 1)) : 1'b0;
                if (spur) disk_rdata = {8{$urandom}};
            end

            if (m_acked) begin
                m_acked = 0; mpend = 0; mem_wr_ack = 1'b0;
                chk("mem_req_drop", 256'(mem_wr_req), 256'(0));
            end else if (mem_wr_req) begin
                mem_wr_ack = 1'b0;
                if (!mpend) begin
                    mpend = 1; m_addr0 = mem_addr; m_data0 = mem_wdata;
                    mwait = ack_rand ? int'($urandom_range(0, 3)) : ack_delay;
                end else begin
                    chk("mem_addr_stable", 256'(mem_addr), 256'(m_addr0));
                    chk("mem_wdata_stable", mem_wdata, m_data0);
                end
                if (mwait == 0) begin
                    mem_wr_ack = 1'b1; m_acked = 1;
                    mem_alog.push_back(mem_addr);
                    mem_dlog.push_back(mem_wdata);
                end else mwait--;
            end else begin
                mem_wr_ack = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    // Interrupt and busy-fall monitor.
    int   irq_q[$];
    int   fall_q[$];
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (dma_done_irq) irq_q.push_back(cyc);
        if (prev_busy && !dma_busy) fall_q.push_back(cyc);
        prev_busy = dma_busy;
    end

    task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
        reg_wr_en = 1'b1; reg_addr = a; reg_wdata = d;
        @(negedge clk);
        reg_wr_en = 1'b0;
    endtask

    task automatic reg_read(input logic [3:0] a, output logic [31:0] d);
        reg_rd_en = 1'b1; reg_addr = a;
        @(negedge clk);
        reg_rd_en = 1'b0;
        d = reg_rdata;
    endtask

    bit exp_done = 0;

    // Program, start (reading INIT_TRAN in the start cycle), wait, and compare
    // the observed line traffic against the expected line list.
    task automatic run_xfer(input logic [31:0] D, input logic [14:0] M, input logic [15:0] T,
                            input bit abuse, input bit chk_time);
        int          L;
        int          start_cyc;
        int          n;
        logic [31:0] rd;
        logic [31:0] ed;
        logic [14:0] em;
        L = (int'(T) + 31) / 32;
        reg_write(4'h0, D);
        reg_write(4'h4, {17'h0, M});
        reg_write(4'h8, {16'h0, T});
        disk_log.delete(); mem_alog.delete(); mem_dlog.delete();
        irq_q.delete(); fall_q.delete();
        reg_wr_en = 1'b1; reg_rd_en = 1'b1; reg_addr = 4'hC; reg_wdata = 32'h1;
        @(negedge clk);
        reg_wr_en = 1'b0; reg_rd_en = 1'b0;
        start_cyc = cyc;
        chk("start_cycle_read", 256'(reg_rdata), 256'(exp_done ? 32'h2 : 32'h0));
        chk("busy_req_after_start", 256'({dma_busy, disk_rd_req}), 256'(2'b11));
        exp_done = 0;
        if (abuse) begin
            reg_write(4'h0, 32'hDEAD_BEE0);
            reg_write(4'h4, 32'h0000_1000);
            reg_write(4'h8, 32'h0000_0020);
            reg_write(4'hC, 32'h1);
            reg_read(4'hC, rd);
            chk("busy_status_read", 256'(rd), 256'(32'h1));
        end
        n = 0;
        while (dma_busy && n < 200 + 40 * L) begin
            @(negedge clk);
            n++;
        end
        chk("xfer_finished", 256'(dma_busy), 256'(0));
        @(negedge clk);
        @(negedge clk);
        chk("irq_count", 256'(irq_q.size()), 256'(1));
        chk("busy_fall_count", 256'(fall_q.size()), 256'(1));
        if (irq_q.size() > 0) begin
            if (chk_time) chk("irq_cycle", 256'(irq_q[0]), 256'(start_cyc + 2 * L));
            if (fall_q.size() > 0) chk("busy_fall_cycle", 256'(fall_q[0]), 256'(irq_q[0] + 1));
        end
        chk("n_disk_lines", 256'(disk_log.size()), 256'(L));
        chk("n_mem_lines", 256'(mem_alog.size()), 256'(L));
        for (int k = 0; k < L; k++) begin
            ed = (D & 32'hFFFF_FFE0) + 32'(32 * k);
            em = 15'((M & 15'h7FE0) + 32 * k);
            if (k < disk_log.size()) chk("disk_addr_seq", 256'(disk_log[k]), 256'(ed));
            if (k < mem_alog.size()) begin
                chk("mem_addr_seq", 256'(mem_alog[k]), 256'(em));
                chk("mem_data_seq", mem_dlog[k], line_data(ed));
            end
        end
        exp_done = 1;
        reg_read(4'hC, rd); chk("done_status", 256'(rd), 256'(32'h2));
        reg_read(4'h0, rd); chk("disk_reg_kept", 256'(rd), 256'(D));
        reg_read(4'h4, rd); chk("mem_reg_kept", 256'(rd), 256'({17'h0, M}));
        reg_read(4'h8, rd); chk("tsize_reg_kept", 256'(rd), 256'({16'h0, T}));
    endtask

    typedef struct {
        bit          wr;
        bit          rd;
        logic [3:0]  a;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [15];

    initial begin
        #900_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  rd;
        logic [255:0] pat;
        logic [31:0]  rD;
        logic [14:0]  rM;
        logic [15:0]  rT;
        bit           ab;

        tbl[0]  = '{1'b0, 1'b1, 4'h0, 32'h0,         32'h0};
        tbl[1]  = '{1'b0, 1'b1, 4'h4, 32'h0,         32'h0};
        tbl[2]  = '{1'b0, 1'b1, 4'h8, 32'h0,         32'h0};
        tbl[3]  = '{1'b0, 1'b1, 4'hC, 32'h0,         32'h0};
        tbl[4]  = '{1'b1, 1'b1, 4'h0, 32'h1234_5678, 32'h1234_5678};
        tbl[5]  = '{1'b1, 1'b1, 4'h4, 32'hFFFF_FFFF, 32'h0000_7FFF};
        tbl[6]  = '{1'b1, 1'b1, 4'h8, 32'hABCD_0040, 32'h0000_0040};
        tbl[7]  = '{1'b1, 1'b1, 4'h1, 32'hFFFF_FFFF, 32'h0};
        tbl[8]  = '{1'b1, 1'b1, 4'h2, 32'hFFFF_FFFF, 32'h0};
        tbl[9]  = '{1'b1, 1'b1, 4'hC, 32'hFFFF_FFFE, 32'h0};
        tbl[10] = '{1'b0, 1'b1, 4'hF, 32'h0,         32'h0};
        tbl[11] = '{1'b1, 1'b1, 4'h8, 32'h0,         32'h0};
        tbl[12] = '{1'b1, 1'b1, 4'hC, 32'h0000_0001, 32'h0};
        tbl[13] = '{1'b0, 1'b1, 4'h4, 32'h0,         32'h0000_7FFF};
        tbl[14] = '{1'b1, 1'b1, 4'h4, 32'h0000_8020, 32'h0000_0020};

        rst_n = 1'b0; reg_wr_en = 1'b0; reg_rd_en = 1'b0; reg_addr = 4'h0; reg_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl_outs", 256'({disk_rd_req, mem_wr_req, dma_busy, dma_done_irq}), 256'(0));
        chk("rst_disk_addr", 256'(disk_addr), 256'(0));
        chk("rst_mem_addr", 256'(mem_addr), 256'(0));
        chk("rst_mem_wdata", mem_wdata, 256'(0));
        chk("rst_rdata", 256'(reg_rdata), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);

        disk_log.delete(); irq_q.delete();
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].wr) reg_write(tbl[i].a, tbl[i].wd);
            if (tbl[i].rd) begin
                reg_read(tbl[i].a, rd);
                chk($sformatf("tbl%0d_rdata", i), 256'(rd), 256'(tbl[i].exp));
            end
        end
        chk("tbl_no_request", 256'(disk_log.size()), 256'(0));
        chk("tbl_idle", 256'(dma_busy), 256'(0));

        // Single line carrying the 0x1F..00 byte ramp.
        run_xfer(32'h100, 15'h40, 16'd32, 0, 1);
        for (int i = 0; i < 32; i++) pat[i*8 +: 8] = 8'(i);
        if (mem_dlog.size() > 0) chk("single_line_pattern", mem_dlog[0], pat);

        // Partial tail, then the same with 5-cycle ack latency.
        run_xfer(32'h100, 15'h40, 16'd70, 0, 1);
        ack_delay = 5;
        run_xfer(32'h100, 15'h40, 16'd70, 0, 0);
        ack_delay = 0;

        // Memory address wrap.
        run_xfer(32'h200, 15'h7FE0, 16'd64, 0, 1);

        // Start with T_SIZE = 0 does nothing and leaves done set.
        reg_write(4'h8, 32'h0);
        disk_log.delete(); irq_q.delete();
        reg_write(4'hC, 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk("zero_size_idle", 256'({dma_busy, disk_rd_req}), 256'(0));
            @(negedge clk);
        end
        chk("zero_size_no_req", 256'(disk_log.size()), 256'(0));
        chk("zero_size_no_irq", 256'(irq_q.size()), 256'(0));
        reg_read(4'hC, rd);
        chk("zero_size_done_kept", 256'(rd), 256'(32'h2));

        // Register writes and a second start while busy are dropped.
        ack_delay = 3;
        run_xfer(32'h300, 15'h100, 16'd200, 1, 0);
        ack_delay = 0;

        // Largest transfer: 2048 lines, memory address wraps twice.
        run_xfer(32'h0, 15'h0, 16'hFFFF, 0, 1);

        // Randomized transfers with stray acks.
        spur = 1;
        for (int it = 0; it < 12; it++) begin
            rD = $urandom;
            if ($urandom_range(0, 3) == 0) rD = 32'hFFFF_FF80 | ($urandom & 32'h3F);
            rM = 15'($urandom);
            rT = 16'($urandom_range(1, 320));
            if ($urandom_range(0, 3) == 0) rT = 16'(32 * $urandom_range(1, 8));
            ack_rand = (it % 2) == 1;
            ab = (rT >= 16'd161) && ($urandom_range(0, 1) == 1);
            run_xfer(rD, rM, rT, ab, !ack_rand);
        end
        spur = 0; ack_rand = 0;

        // Asynchronous reset in the middle of a transfer.
        ack_delay = 1;
        reg_write(4'h0, 32'h400);
        reg_write(4'h4, 32'h200);
        reg_write(4'h8, 32'd256);
        irq_q.delete();
        reg_write(4'hC, 32'h1);
        repeat (5) @(negedge clk);
        chk("mid_busy", 256'(dma_busy), 256'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ctrl_outs", 256'({disk_rd_req, mem_wr_req, dma_busy, dma_done_irq}), 256'(0));
        chk("arst_disk_addr", 256'(disk_addr), 256'(0));
        chk("arst_mem_addr", 256'(mem_addr), 256'(0));
        chk("arst_mem_wdata", mem_wdata, 256'(0));
        chk("arst_rdata", 256'(reg_rdata), 256'(0));
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("arst_no_irq", 256'(irq_q.size()), 256'(0));
        reg_read(4'hC, rd); chk("arst_status", 256'(rd), 256'(0));
        reg_read(4'h0, rd); chk("arst_disk_reg", 256'(rd), 256'(0));
        ack_delay = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
